// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_pkg
//  Description : Shared access-mode encodings and sizing helpers for the
//                flagged synchronous FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    // Access modes, encoded as {write_en, read_en}
    localparam logic [1:0] READ  = 2'b01;
    localparam logic [1:0] WRITE = 2'b10;
    localparam logic [1:0] BOTH  = 2'b11;

    // Occupancy counter must represent 0..depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_flagged_if.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_flagged_if
//  Description : Producer/consumer bus of the flagged synchronous FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_flagged_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32
) ();
    localparam int CNT_W = count_width(FIFO_DEPTH);

    logic                  clear_i;
    logic                  write_i;
    logic [DATA_WIDTH-1:0] wr_data_i;
    logic                  read_i;
    logic [DATA_WIDTH-1:0] rd_data_o;
    logic                  full_o;
    logic                  empty_o;
    logic                  almost_full_o;
    logic                  almost_empty_o;
    logic [CNT_W-1:0]      count_o;
    logic                  overflow_o;
    logic                  underflow_o;

    modport master (
        output clear_i, write_i, wr_data_i, read_i,
        input  rd_data_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, overflow_o, underflow_o
    );

    modport slave (
        input  clear_i, write_i, wr_data_i, read_i,
        output rd_data_o, full_o, empty_o, almost_full_o, almost_empty_o,
               count_o, overflow_o, underflow_o
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_ram
//  Description : FIFO storage; combinational (FWFT) or registered read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_ram #(
    parameter  int DATA_WIDTH = 32,
    parameter  int FIFO_DEPTH = 32,
    parameter  int FWFT       = 1,
    localparam int ADDR_W     = $clog2(FIFO_DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_wr_en,
    input  wire logic [ADDR_W-1:0]     i_wr_addr,
    input  wire logic [DATA_WIDTH-1:0] i_wr_data,
    input  wire logic                  i_rd_en,
    input  wire logic [ADDR_W-1:0]     i_rd_addr,
    output logic      [DATA_WIDTH-1:0] o_rd_data
);
    // Storage is deliberately left out of reset
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            logic w_unused_fwft;
            assign w_unused_fwft = rst | i_rd_en;
            assign o_rd_data     = r_mem[i_rd_addr];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] r_rd_data;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_rd_data <= '0;
                end else if (i_rd_en) begin
                    r_rd_data <= r_mem[i_rd_addr];
                end
            end
            assign o_rd_data = r_rd_data;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/sync_fifo_flagged.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_flagged
//  Description : Single-clock FIFO with arbitrary depth, occupancy count,
//                threshold flags, sticky error flags and synchronous flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_flagged
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FIFO_DEPTH    = 32,
    parameter int FWFT          = 1,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input wire logic          clk_i,
    input wire logic          rst_i,
    sync_fifo_flagged_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = count_width(FIFO_DEPTH);

    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full, r_empty, r_afull, r_aempty, r_ovf, r_udf;

    logic             w_wr_en, w_rd_en;
    logic [CNT_W-1:0] w_count_next;

    assign w_wr_en = bus.write_i & ~r_full;
    assign w_rd_en = bus.read_i  & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_en, w_rd_en})
            WRITE:   w_count_next = r_count + 1'b1;
            READ:    w_count_next = r_count - 1'b1;
            BOTH:    w_count_next = r_count;
            default: w_count_next = r_count;
        endcase
    end

    // Explicit wrap: depth need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i || bus.clear_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= (AFULL_THRESH <= 0);
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_en) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_rd_en) r_rd_ptr <= ptr_inc(r_rd_ptr);
            r_count  <= w_count_next;
            r_full   <= (w_count_next == CNT_W'(FIFO_DEPTH));
            r_empty  <= (w_count_next == '0);
            r_afull  <= (w_count_next >= CNT_W'(AFULL_THRESH));
            r_aempty <= (w_count_next <= CNT_W'(AEMPTY_THRESH));
            if (bus.write_i && r_full)  r_ovf <= 1'b1;
            if (bus.read_i  && r_empty) r_udf <= 1'b1;
        end
    end

    sync_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .FWFT       (FWFT)
    ) u_ram (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_wr_en   (w_wr_en & ~bus.clear_i & ~rst_i),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.wr_data_i),
        .i_rd_en   (w_rd_en & ~bus.clear_i),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (bus.rd_data_o)
    );

    assign bus.full_o         = r_full;
    assign bus.empty_o        = r_empty;
    assign bus.almost_full_o  = r_afull;
    assign bus.almost_empty_o = r_aempty;
    assign bus.count_o        = r_count;
    assign bus.overflow_o     = r_ovf;
    assign bus.underflow_o    = r_udf;
endmodule
`default_nettype wire
